half_mant_seq_mul: RTL and testbench

Iterative shift-and-add mantissa multiplier for the half-precision floating-point datapath. It consumes two MANT_W-bit significands (hidden bit included) and produces the raw product, plus a normalized, rounded significand with an exponent-increment flag for the exponent stage. The block is paced by an internal saturating step counter that runs 0 to MANT_W+2 per operation, so latency is fixed and known to downstream control.

---
 rtl/fp_half_pkg.sv | 27 ++
 rtl/mul_step_counter.sv | 30 +++
 rtl/half_mant_seq_mul.sv | 179 +++++++++++++++++
 tb/tb_half_mant_seq_mul.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_half_pkg.sv
// Shared types and constants for the half-precision significand multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_half_pkg;

    localparam int MANT_W_DEF = 11;                 // significand width incl. hidden bit
    localparam int STEP_LAST  = MANT_W_DEF + 2;     // terminal step count
    localparam int CNT_W      = $clog2(MANT_W_DEF + 3);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Terminal count and counter width for a non-default significand width.
    function automatic int step_last_of(input int mant_w);
        return mant_w + 2;
    endfunction

    function automatic int cnt_w_of(input int mant_w);
        return $clog2(mant_w + 3);
    endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Saturating step counter that paces the multiplier sequence.
// Latency: count updates one cycle after clear/increment.
// Backpressure: none; clear wins over increment, holds at LAST.
//
// Ports: clk, rst (sync, active-high), clr (restart at 0),
//        cnt (current step), at_last (cnt == LAST).
module mul_step_counter #(
    parameter int CNT_W = 4,
    parameter int LAST  = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_last
);

    assign at_last = (cnt == CNT_W'(LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/half_mant_seq_mul.sv
// Shift-and-add significand multiplier with normalize and optional RNE round.
// Latency: start accepted at edge k -> done high in the cycle after edge k+MANT_W+3.
// Backpressure: start only accepted while ready (IDLE/DONE); ignored while busy.
//
// Ports: clk, rst (sync, active-high); start, a_mant, b_mant (operands captured
// on accepted start); ready, busy, done (one-cycle pulse); prod (raw product),
// mant_out (normalized significand), exp_inc, inexact (registered, stable from
// DONE until the ROUND step of the next operation).
// Build option: define HALF_MUL_ROUND_EN to enable round-to-nearest-even;
// otherwise mant_out is the truncated normalized significand.
module half_mant_seq_mul
    import fp_half_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MANT_W-1:0]     a_mant,
    input  logic [MANT_W-1:0]     b_mant,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [2*MANT_W-1:0]   prod,
    output logic [MANT_W-1:0]     mant_out,
    output logic                  exp_inc,
    output logic                  inexact
);

    localparam int LAST = step_last_of(MANT_W);
    localparam int CW   = cnt_w_of(MANT_W);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_last;
    logic            accept;

    logic [MANT_W-1:0] mcand, mplier, acc;
    logic [MANT_W:0]   add_sum;
    logic [2*MANT_W-1:0] prod_w;

    logic [MANT_W-1:0] n_mant, nc_mant;
    logic              n_guard, n_sticky, n_exp;
    logic              nc_guard, nc_sticky, nc_exp;
    logic [MANT_W-1:0] mant_fin;
    logic              exp_fin;

    assign accept = start && ready;

    mul_step_counter #(
        .CNT_W (CW),
        .LAST  (LAST)
    ) u_step_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .cnt     (cnt),
        .at_last (cnt_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // MUL runs W add/shift steps (counts 0..W-1) plus one settle cycle at
    // count W, so NORM lands at W+1 and ROUND at the saturated terminal count.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_MUL;
            ST_MUL:   if (cnt == CW'(MANT_W)) state_nxt = ST_NORM;
            ST_NORM:  state_nxt = ST_ROUND;
            ST_ROUND: if (cnt_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_MUL : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            ST_IDLE:                  ready = 1'b1;
            ST_MUL, ST_NORM, ST_ROUND: busy = 1'b1;
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- shift-and-add datapath ----------------
    // add_sum carries the extra bit; shifting {add_sum, mplier} right by one
    // moves the sum LSB into the vacated multiplier MSB.
    assign add_sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    assign prod_w  = {acc, mplier};

    // Single-position normalization: product of two W-bit values is below
    // 2^(2W), so either the top bit or the one below it leads.
    always_comb begin
        nc_mant   = prod_w[2*MANT_W-2:MANT_W-1];
        nc_guard  = prod_w[MANT_W-2];
        nc_sticky = |prod_w[MANT_W-3:0];
        nc_exp    = 1'b0;
        if (prod_w[2*MANT_W-1]) begin
            nc_mant   = prod_w[2*MANT_W-1:MANT_W];
            nc_guard  = prod_w[MANT_W-1];
            nc_sticky = |prod_w[MANT_W-2:0];
            nc_exp    = 1'b1;
        end
    end

`ifdef HALF_MUL_ROUND_EN
    logic            rnd_inc;
    logic [MANT_W:0] rnd_sum;
    always_comb begin
        rnd_inc  = n_guard & (n_sticky | n_mant[0]);
        rnd_sum  = {1'b0, n_mant} + {{MANT_W{1'b0}}, rnd_inc};
        mant_fin = rnd_sum[MANT_W-1:0];
        exp_fin  = n_exp;
        // All-ones significand rounded up wraps to 1.000...; bump exponent.
        if (rnd_sum[MANT_W]) begin
            mant_fin = {1'b1, {(MANT_W-1){1'b0}}};
            exp_fin  = 1'b1;
        end
    end
`else
    always_comb begin
        mant_fin = n_mant;
        exp_fin  = n_exp;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            n_mant   <= '0;
            n_guard  <= 1'b0;
            n_sticky <= 1'b0;
            n_exp    <= 1'b0;
            prod     <= '0;
            mant_out <= '0;
            exp_inc  <= 1'b0;
            inexact  <= 1'b0;
        end else begin
            if (accept) begin
                mcand  <= a_mant;
                mplier <= b_mant;
                acc    <= '0;
            end else if (state == ST_MUL && cnt < CW'(MANT_W)) begin
                acc    <= add_sum[MANT_W:1];
                mplier <= {add_sum[0], mplier[MANT_W-1:1]};
            end

            if (state == ST_NORM) begin
                n_mant   <= nc_mant;
                n_guard  <= nc_guard;
                n_sticky <= nc_sticky;
                n_exp    <= nc_exp;
            end

            if (state == ST_ROUND) begin
                prod     <= prod_w;
                mant_out <= mant_fin;
                exp_inc  <= exp_fin;
                inexact  <= n_guard | n_sticky;
            end
        end
    end

endmodule

// File: tb/tb_half_mant_seq_mul.sv
module tb_half_mant_seq_mul;
    import fp_half_pkg::*;

    localparam int W   = MANT_W_DEF;
    localparam int LAT = W + 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a_mant, b_mant;
    logic           ready, busy, done;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mant_out;
    logic           exp_inc, inexact;

    half_mant_seq_mul #(.MANT_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_mant   (a_mant),
        .b_mant   (b_mant),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .prod     (prod),
        .mant_out (mant_out),
        .exp_inc  (exp_inc),
        .inexact  (inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        longint prod;
        longint mant;
        longint exp_inc;
        longint inexact;
        int     acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: exact integer product, then pick the leading position and
    // split into kept significand and discarded remainder.
    function automatic exp_t model(input int a, input int b);
        exp_t   e;
        longint p, m, rem, half;
        int     sh;
        p    = longint'(a) * longint'(b);
        sh   = (p >= (longint'(1) << (2*W-1))) ? W : W-1;
        m    = p >> sh;
        rem  = p - (m << sh);
        half = longint'(1) << (sh-1);
        e.prod    = p;
        e.exp_inc = (sh == W) ? 1 : 0;
        e.inexact = (rem != 0) ? 1 : 0;
`ifdef HALF_MUL_ROUND_EN
        if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
        if (m == (longint'(1) << W)) begin
            m = longint'(1) << (W-1);
            e.exp_inc = 1;
        end
`endif
        e.mant    = m;
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done && !rst) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("prod",     prod,     e.prod);
                chk("mant_out", mant_out, e.mant);
                chk("exp_inc",  exp_inc,  e.exp_inc);
                chk("inexact",  inexact,  e.inexact);
                chk("latency",  cyc - e.acc_cyc, LAT);
            end
        end
    end

    // Called at a negedge; returns at a negedge with start low.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("issue_ready", ready, 1);
        if (ready) begin
            start  = 1'b1;
            a_mant = a;
            b_mant = b;
            e = model(int'(a), int'(b));
            e.acc_cyc = cyc + 1;
            sbq.push_back(e);
            @(negedge clk);
            start  = 1'b0;
            a_mant = W'($urandom);
            b_mant = W'($urandom);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", done, 1);
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = W'($urandom);
        if ($urandom_range(0, 3) != 0) v[W-1] = 1'b1;
        if ($urandom_range(0, 15) == 0) v = '0;
        return v;
    endfunction

    logic [W-1:0] dir_a [6] = '{11'h400, 11'h600, 11'h417, 11'h7FF, 11'h000, 11'h7FF};
    logic [W-1:0] dir_b [6] = '{11'h400, 11'h600, 11'h417, 11'h7FF, 11'h7FF, 11'h000};

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_mant = '0;
        b_mant = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   ready,    1);
        chk("rst_busy",    busy,     0);
        chk("rst_done",    done,     0);
        chk("rst_prod",    prod,     0);
        chk("rst_mant",    mant_out, 0);
        chk("rst_exp_inc", exp_inc,  0);
        chk("rst_inexact", inexact,  0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, each run to completion.
        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i]);
            wait_done();
            @(negedge clk);
        end

        // Start while busy is ignored; start in DONE is taken back-to-back.
        issue(11'h5A5, 11'h6C3);
        repeat (3) @(negedge clk);
        chk("busy_mid", busy, 1);
        chk("ready_mid", ready, 0);
        start  = 1'b1;
        a_mant = rand_op();
        b_mant = rand_op();
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("ready_in_done", ready, 1);
        issue(11'h7FF, 11'h7FE);
        issue(11'h4D2, 11'h789);
        wait_done();
        @(negedge clk);

        // Reset in the middle of an operation: outputs clear, no done.
        issue(11'h7FF, 11'h7FF);
        wait_done();
        @(negedge clk);
        issue(11'h6A1, 11'h53F);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready",   ready,    1);
        chk("mid_rst_busy",    busy,     0);
        chk("mid_rst_prod",    prod,     0);
        chk("mid_rst_mant",    mant_out, 0);
        chk("mid_rst_exp_inc", exp_inc,  0);
        chk("mid_rst_inexact", inexact,  0);
        repeat (20) @(negedge clk);
        issue(11'h417, 11'h417);
        wait_done();
        @(negedge clk);

        // Randomized traffic, mostly back-to-back.
        for (int i = 0; i < 40; i++) begin
            issue(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        begin
            int t = 0;
            while (sbq.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("drain", sbq.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
